// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: per-channel synchronizer plus stability counter,
// with rise/fall pulses. Optional long-press detector is enabled with `define LONG_PRESS_EN.

module debounce_ch #(
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic db,
  output logic rise,
  output logic fall,
  output logic lng
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;
  logic                   flip;

  assign sync = sync_q[SYNC_STAGES-1];
  assign flip = (sync != db) && (cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      db     <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pb};
      rise   <= flip & sync;
      fall   <= flip & ~sync;
      // Any sample that agrees with the current level restarts qualification
      if (sync == db) begin
        cnt <= '0;
      end else if (flip) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);

  logic [LW-1:0] hcnt;
  logic          fired;

  // fired keeps the saturated counter from re-triggering within one press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      fired <= 1'b0;
      lng   <= 1'b0;
    end else if (!db) begin
      hcnt  <= '0;
      fired <= 1'b0;
      lng   <= 1'b0;
    end else begin
      lng <= 1'b0;
      if (hcnt != LW'(LONG_CYCLES - 1)) begin
        hcnt <= hcnt + 1'b1;
      end else if (!fired) begin
        lng   <= 1'b1;
        fired <= 1'b1;
      end
    end
  end
`else
  assign lng = 1'b0;
`endif

endmodule

module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse
);
  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_CYCLES < 2) begin : g_param_err
    $error("debounce_multi: STABLE_CYCLES, SYNC_STAGES and LONG_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .pb   (pb_in[i]),
      .db   (db_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i]),
      .lng  (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: directed scenarios plus random bounce traffic,
// checked against a sample-window reference model.

module tb_debounce_multi;
  localparam int N_CH          = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int LONG_CYCLES   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] pb_in;
  logic [N_CH-1:0] db_out, rise_pulse, fall_pulse, long_pulse;

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
    .db_out(db_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .long_pulse(long_pulse)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit done   = 1'b0;

  typedef struct packed {
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] lng;
  } obs_t;

  obs_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: the level flips when the last STABLE_CYCLES synchronized
  // samples all disagree with it; the synchronized sample is pb_in as seen
  // SYNC_STAGES edges earlier (zeros right after reset).
  initial begin
    logic [N_CH-1:0] pbq[$];
    logic [N_CH-1:0] win[$];
    logic [N_CH-1:0] m_db, s;
    obs_t            e;
    bit              all_diff;
    int              ei;
`ifdef LONG_PRESS_EN
    int              rise_idx[N_CH];
`endif
    m_db = '0;
    ei   = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        pbq = {};
        for (int k = 0; k < SYNC_STAGES; k++) pbq.push_back('0);
        win  = {};
        m_db = '0;
        ei   = 0;
      end else begin
        ei++;
        s = pbq.pop_front();
        pbq.push_back(pb_in);
        win.push_back(s);
        if (win.size() > STABLE_CYCLES) void'(win.pop_front());
        for (int c = 0; c < N_CH; c++) begin
`ifdef LONG_PRESS_EN
          if (m_db[c] && (ei - rise_idx[c] == LONG_CYCLES)) e.lng[c] = 1'b1;
`endif
          if (win.size() == STABLE_CYCLES) begin
            all_diff = 1'b1;
            foreach (win[j]) if (win[j][c] == m_db[c]) all_diff = 1'b0;
            if (all_diff) begin
              if (!m_db[c]) begin
                e.rise[c] = 1'b1;
`ifdef LONG_PRESS_EN
                rise_idx[c] = ei;
`endif
              end else begin
                e.fall[c] = 1'b1;
              end
              m_db[c] = ~m_db[c];
            end
          end
        end
      end
      e.db = m_db;
      expq.push_back(e);
    end
  end

  // Monitor: one observation per cycle, sampled 1 ns after the rising edge
  initial begin
    obs_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (expq.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = expq.pop_front();
        chk("outputs", {db_out, rise_pulse, fall_pulse, long_pulse}, e);
        chk("rise_fall_excl", 32'(rise_pulse & fall_pulse), 32'd0);
      end
    end
  end

  // Waits (bounded) for db_out[ch]==val; returns edges counted from the call
  task automatic wait_db(input int ch, input logic val, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (db_out[ch] !== val && edges < 40);
  endtask

  initial begin
    int edges, nlong;
    rst_n = 1'b0;
    pb_in = 4'hF;

    // 1: reset with inputs high, then qualify all channels
    repeat (3) @(negedge clk);
    chk("reset_outputs", {db_out, rise_pulse, fall_pulse, long_pulse}, 32'd0);
    rst_n = 1'b1;
    wait_db(0, 1'b1, edges);
    chk("reset_exit_latency", edges, 32'd10);
    chk("reset_exit_db", 32'(db_out), 32'hF);
    chk("reset_exit_rise", 32'(rise_pulse), 32'hF);
    @(posedge clk); #1;
    chk("rise_one_cycle", 32'(rise_pulse), 32'h0);

    // 2: bounce on ch0, then steady high
    @(negedge clk);
    pb_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      pb_in[0] = ~pb_in[0];
      repeat (3) @(negedge clk);
    end
    pb_in[0] = 1'b1;
    wait_db(0, 1'b1, edges);
    chk("bounce_latency", edges, 32'd10);

    // 3: glitch on ch1 of 7 cycles (rejected) then 9 cycles (accepted)
    @(negedge clk);
    pb_in[1] = 1'b0;
    repeat (7) @(negedge clk);
    pb_in[1] = 1'b1;
    repeat (15) @(negedge clk);
    chk("glitch7_db1", 32'(db_out[1]), 32'd1);
    pb_in[1] = 1'b0;
    repeat (9) @(negedge clk);
    pb_in[1] = 1'b1;
    repeat (15) @(negedge clk);

    // 4: ch2 press and ch3 release on the same cycle
    pb_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    pb_in[2] = 1'b1;
    pb_in[3] = 1'b0;
    repeat (14) @(negedge clk);

    // 5: reset in the middle of a qualification
    pb_in = 4'h0;
    repeat (12) @(negedge clk);
    pb_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_db", 32'(db_out), 32'd0);
    rst_n = 1'b1;
    wait_db(0, 1'b1, edges);
    chk("midreset_requal", edges, 32'd10);

    // 6: long hold on ch0
    nlong = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (long_pulse[0]) nlong++;
    end
`ifdef LONG_PRESS_EN
    chk("long_count", nlong, 32'd1);
`else
    chk("long_count", nlong, 32'd0);
`endif

    // Random bounce traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 9) == 0) pb_in[c] = ~pb_in[c];
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    done = 1'b1;
    #50;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
